// File: rtl/id_ex_reg_if.sv
// ID->EX pipeline bundle: ID-stage values in, registered EX-stage copies out.
interface id_ex_reg_if #(parameter int CNT_W = 16);
  logic              RegDst_in,  ALUSrc_in,  MemToReg_in, RegWrite_in, MemRead_in;
  logic              MemWrite_in, Branch_in, Bne_in,      Jump_in;
  logic [1:0]        ALUOp_in,   Jdes_sel_in;
  logic [2:0]        trunk_mode_in;
  logic [31:0]       pc_plus4_in, read_data1_in, read_data2_in, sign_ext_in;
  logic [4:0]        rs_in, rt_in, rd_in;
  logic [5:0]        funct_in;

  logic              RegDst_out,  ALUSrc_out,  MemToReg_out, RegWrite_out, MemRead_out;
  logic              MemWrite_out, Branch_out, Bne_out,      Jump_out;
  logic [1:0]        ALUOp_out,   Jdes_sel_out;
  logic [2:0]        trunk_mode_out;
  logic [31:0]       pc_plus4_out, read_data1_out, read_data2_out, sign_ext_out;
  logic [4:0]        rs_out, rt_out, rd_out;
  logic [5:0]        funct_out;
  logic              valid_out;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in,
           MemWrite_in, Branch_in, Bne_in, Jump_in, ALUOp_in, Jdes_sel_in,
           trunk_mode_in, pc_plus4_in, read_data1_in, read_data2_in,
           sign_ext_in, rs_in, rt_in, rd_in, funct_in,
    input  RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out,
           MemWrite_out, Branch_out, Bne_out, Jump_out, ALUOp_out, Jdes_sel_out,
           trunk_mode_out, pc_plus4_out, read_data1_out, read_data2_out,
           sign_ext_out, rs_out, rt_out, rd_out, funct_out,
           valid_out, bubble_count
  );

  modport slave (
    input  RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in,
           MemWrite_in, Branch_in, Bne_in, Jump_in, ALUOp_in, Jdes_sel_in,
           trunk_mode_in, pc_plus4_in, read_data1_in, read_data2_in,
           sign_ext_in, rs_in, rt_in, rd_in, funct_in,
    output RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out,
           MemWrite_out, Branch_out, Bne_out, Jump_out, ALUOp_out, Jdes_sel_out,
           trunk_mode_out, pc_plus4_out, read_data1_out, read_data2_out,
           sign_ext_out, rs_out, rt_out, rd_out, funct_out,
           valid_out, bubble_count
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load, stall (hold) and flush (bubble insertion),
// with a saturating count of inserted bubbles.
module id_ex_reg #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  id_ex_reg_if.slave  bus
);

  // Flush takes priority over stall so a bubble is always inserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.RegDst_out     <= 1'b0;
      bus.ALUSrc_out     <= 1'b0;
      bus.MemToReg_out   <= 1'b0;
      bus.RegWrite_out   <= 1'b0;
      bus.MemRead_out    <= 1'b0;
      bus.MemWrite_out   <= 1'b0;
      bus.Branch_out     <= 1'b0;
      bus.Bne_out        <= 1'b0;
      bus.Jump_out       <= 1'b0;
      bus.ALUOp_out      <= '0;
      bus.Jdes_sel_out   <= '0;
      bus.trunk_mode_out <= '0;
      bus.pc_plus4_out   <= '0;
      bus.read_data1_out <= '0;
      bus.read_data2_out <= '0;
      bus.sign_ext_out   <= '0;
      bus.rs_out         <= '0;
      bus.rt_out         <= '0;
      bus.rd_out         <= '0;
      bus.funct_out      <= '0;
      bus.valid_out      <= 1'b0;
      bus.bubble_count   <= '0;
    end else if (flush) begin
      bus.RegDst_out     <= 1'b0;
      bus.ALUSrc_out     <= 1'b0;
      bus.MemToReg_out   <= 1'b0;
      bus.RegWrite_out   <= 1'b0;
      bus.MemRead_out    <= 1'b0;
      bus.MemWrite_out   <= 1'b0;
      bus.Branch_out     <= 1'b0;
      bus.Bne_out        <= 1'b0;
      bus.Jump_out       <= 1'b0;
      bus.ALUOp_out      <= '0;
      bus.Jdes_sel_out   <= '0;
      bus.trunk_mode_out <= '0;
      bus.pc_plus4_out   <= '0;
      bus.read_data1_out <= '0;
      bus.read_data2_out <= '0;
      bus.sign_ext_out   <= '0;
      bus.rs_out         <= '0;
      bus.rt_out         <= '0;
      bus.rd_out         <= '0;
      bus.funct_out      <= '0;
      bus.valid_out      <= 1'b0;
      if (bus.bubble_count != '1)
        bus.bubble_count <= bus.bubble_count + 1'b1;
    end else if (!stall) begin
      bus.RegDst_out     <= bus.RegDst_in;
      bus.ALUSrc_out     <= bus.ALUSrc_in;
      bus.MemToReg_out   <= bus.MemToReg_in;
      bus.RegWrite_out   <= bus.RegWrite_in;
      bus.MemRead_out    <= bus.MemRead_in;
      bus.MemWrite_out   <= bus.MemWrite_in;
      bus.Branch_out     <= bus.Branch_in;
      bus.Bne_out        <= bus.Bne_in;
      bus.Jump_out       <= bus.Jump_in;
      bus.ALUOp_out      <= bus.ALUOp_in;
      bus.Jdes_sel_out   <= bus.Jdes_sel_in;
      bus.trunk_mode_out <= bus.trunk_mode_in;
      bus.pc_plus4_out   <= bus.pc_plus4_in;
      bus.read_data1_out <= bus.read_data1_in;
      bus.read_data2_out <= bus.read_data2_in;
      bus.sign_ext_out   <= bus.sign_ext_in;
      bus.rs_out         <= bus.rs_in;
      bus.rt_out         <= bus.rt_in;
      bus.rd_out         <= bus.rd_in;
      bus.funct_out      <= bus.funct_in;
      bus.valid_out      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: vector table plus directed sequences,
// expected values flow through a scoreboard queue.
module tb_id_ex_reg;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read;
    logic        mem_write, branch, bne, jump;
    logic [1:0]  alu_op, jdes_sel;
    logic [2:0]  trunk_mode;
    logic [31:0] pc_plus4, rd1, rd2, sext;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
  } bundle_t;

  typedef struct {
    bundle_t out;
    logic    valid;
    int      cnt;
  } exp_t;

  typedef struct {
    logic    flush;
    logic    stall;
    bundle_t in;
    logic    exp_valid;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;

  id_ex_reg_if #(.CNT_W(CNT_W)) bus ();

  id_ex_reg #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  bundle_t m_out = '0;
  logic    m_valid = 1'b0;
  int      m_cnt = 0;

  task automatic drive(input bundle_t b);
    bus.RegDst_in     = b.reg_dst;
    bus.ALUSrc_in     = b.alu_src;
    bus.MemToReg_in   = b.mem_to_reg;
    bus.RegWrite_in   = b.reg_write;
    bus.MemRead_in    = b.mem_read;
    bus.MemWrite_in   = b.mem_write;
    bus.Branch_in     = b.branch;
    bus.Bne_in        = b.bne;
    bus.Jump_in       = b.jump;
    bus.ALUOp_in      = b.alu_op;
    bus.Jdes_sel_in   = b.jdes_sel;
    bus.trunk_mode_in = b.trunk_mode;
    bus.pc_plus4_in   = b.pc_plus4;
    bus.read_data1_in = b.rd1;
    bus.read_data2_in = b.rd2;
    bus.sign_ext_in   = b.sext;
    bus.rs_in         = b.rs;
    bus.rt_in         = b.rt;
    bus.rd_in         = b.rd;
    bus.funct_in      = b.funct;
  endtask

  function automatic bundle_t get_out();
    bundle_t b;
    b.reg_dst    = bus.RegDst_out;
    b.alu_src    = bus.ALUSrc_out;
    b.mem_to_reg = bus.MemToReg_out;
    b.reg_write  = bus.RegWrite_out;
    b.mem_read   = bus.MemRead_out;
    b.mem_write  = bus.MemWrite_out;
    b.branch     = bus.Branch_out;
    b.bne        = bus.Bne_out;
    b.jump       = bus.Jump_out;
    b.alu_op     = bus.ALUOp_out;
    b.jdes_sel   = bus.Jdes_sel_out;
    b.trunk_mode = bus.trunk_mode_out;
    b.pc_plus4   = bus.pc_plus4_out;
    b.rd1        = bus.read_data1_out;
    b.rd2        = bus.read_data2_out;
    b.sext       = bus.sign_ext_out;
    b.rs         = bus.rs_out;
    b.rt         = bus.rt_out;
    b.rd         = bus.rd_out;
    b.funct      = bus.funct_out;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return bundle_t'(r[$bits(bundle_t)-1:0]);
  endfunction

  task automatic chk_bundle(input string name, input bundle_t act, input bundle_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge: drive, predict, then compare after the edge.
  task automatic step(input logic f, input logic s, input bundle_t b, input string name);
    exp_t e;
    @(negedge clk);
    flush = f;
    stall = s;
    drive(b);
    if (f) begin
      m_out   = '0;
      m_valid = 1'b0;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (!s) begin
      m_out   = b;
      m_valid = 1'b1;
    end
    e.out = m_out; e.valid = m_valid; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk_bundle({name, ".outs"}, get_out(), e.out);
    chk_val({name, ".valid"}, 32'(bus.valid_out), 32'(e.valid));
    chk_val({name, ".count"}, 32'(bus.bubble_count), 32'(e.cnt));
  endtask

  vec_t    vecs[11];
  bundle_t b;
  logic [3:0] cnt_before;

  initial begin
    drive(rand_bundle());
    #3;
    chk_bundle("reset.outs", get_out(), '0);
    chk_val("reset.valid", 32'(bus.valid_out), 0);
    chk_val("reset.count", 32'(bus.bubble_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic load with known field values.
    b = '0;
    b.reg_write = 1'b1; b.alu_op = 2'b10; b.reg_dst = 1'b1;
    b.rs = 5'd3; b.rt = 5'd4; b.rd = 5'd5; b.funct = 6'h20; b.rd1 = 32'h0000_0010;
    step(1'b0, 1'b0, b, "load");
    chk_val("load.rd", 32'(bus.rd_out), 32'd5);
    chk_val("load.funct", 32'(bus.funct_out), 32'h20);

    // Load an LBU then hold it through three stalled edges.
    b = rand_bundle(); b.mem_read = 1'b1; b.trunk_mode = 3'd3;
    step(1'b0, 1'b0, b, "lbu_load");
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, rand_bundle(), "stall_hold");
      chk_val("stall.trunk", 32'(bus.trunk_mode_out), 32'd3);
      chk_val("stall.memread", 32'(bus.MemRead_out), 32'd1);
    end

    // JAL loaded, then flush with stall also high.
    b = rand_bundle(); b.jump = 1'b1; b.jdes_sel = 2'b01;
    step(1'b0, 1'b0, b, "jal_load");
    cnt_before = bus.bubble_count;
    step(1'b1, 1'b1, rand_bundle(), "flush_over_stall");
    chk_val("flush_over_stall.inc", 32'(bus.bubble_count), 32'(cnt_before) + 1);

    // Back-to-back load / flush / load.
    step(1'b0, 1'b0, rand_bundle(), "b2b_load1");
    chk_val("b2b.v1", 32'(bus.valid_out), 1);
    step(1'b1, 1'b0, rand_bundle(), "b2b_flush");
    chk_val("b2b.v2", 32'(bus.valid_out), 0);
    step(1'b0, 1'b0, rand_bundle(), "b2b_load2");
    chk_val("b2b.v3", 32'(bus.valid_out), 1);

    // Mixed vector table.
    vecs[0]  = '{1'b0, 1'b0, rand_bundle(), 1'b1};
    vecs[1]  = '{1'b0, 1'b1, rand_bundle(), 1'b1};
    vecs[2]  = '{1'b1, 1'b0, rand_bundle(), 1'b0};
    vecs[3]  = '{1'b0, 1'b1, rand_bundle(), 1'b0};
    vecs[4]  = '{1'b0, 1'b0, rand_bundle(), 1'b1};
    vecs[5]  = '{1'b1, 1'b1, rand_bundle(), 1'b0};
    vecs[6]  = '{1'b0, 1'b0, rand_bundle(), 1'b1};
    vecs[7]  = '{1'b0, 1'b0, rand_bundle(), 1'b1};
    vecs[8]  = '{1'b0, 1'b1, rand_bundle(), 1'b1};
    vecs[9]  = '{1'b1, 1'b0, rand_bundle(), 1'b0};
    vecs[10] = '{1'b0, 1'b0, rand_bundle(), 1'b1};
    for (int unsigned i = 0; i < 11; i++) begin
      step(vecs[i].flush, vecs[i].stall, vecs[i].in, "vec");
      chk_val("vec.valid_tbl", 32'(bus.valid_out), 32'(vecs[i].exp_valid));
    end

    // Saturation of the bubble counter.
    for (int unsigned i = 0; i < 20; i++)
      step(1'b1, 1'b0, rand_bundle(), "sat");
    chk_val("sat.final", 32'(bus.bubble_count), CNT_MAX);
    step(1'b0, 1'b0, rand_bundle(), "sat_load");
    chk_val("sat.after_load", 32'(bus.bubble_count), CNT_MAX);

    // Asynchronous reset between edges.
    b = rand_bundle(); b.mem_write = 1'b1;
    step(1'b0, 1'b0, b, "mw_load");
    chk_val("mw_load.memwrite", 32'(bus.MemWrite_out), 1);
    #1;
    reset = 1'b1;
    #1;
    chk_bundle("async_reset.outs", get_out(), '0);
    chk_val("async_reset.valid", 32'(bus.valid_out), 0);
    chk_val("async_reset.count", 32'(bus.bubble_count), 0);
    #1;
    reset = 1'b0;
    m_out = '0; m_valid = 1'b0; m_cnt = 0;
    step(1'b0, 1'b0, rand_bundle(), "post_reset_load");

    chk_val("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: CNT_W, 16, width of the bubble counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  hold: all registered outputs keep their current value.
REQ-005 flush  in  1  insert bubble: next cycle carries a NOP.
REQ-006 RegDst_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in, Bne_in, Jump_in  in  1 each  ID-stage control bits.
REQ-007 ALUOp_in, Jdes_sel_in  in  2 each  ID-stage control fields.
REQ-008 trunk_mode_in  in  3  load/store truncation mode, where 0 = word, 1 = signed byte, 2 = signed half, 3 = unsigned byte, 4 = unsigned half.
REQ-009 pc_plus4_in, read_data1_in, read_data2_in, sign_ext_in  in  32 each  ID-stage datapath values.
REQ-010 rs_in, rt_in, rd_in  in  5 each  register specifiers.
REQ-011 funct_in  in  6  instruction function field.
REQ-012 Each of REQ-006..REQ-011 SHALL have an `<name>_out` output of the same width holding the registered EX-stage copy; `_in` is replaced by `_out`.
REQ-013 valid_out  out  1  1 = EX stage holds a real instruction; 0 = bubble.
REQ-014 bubble_count  out  CNT_W  saturating count of bubbles inserted by flush.

Function
REQ-015 Update priority SHALL be: reset, then flush, then stall, then load.
REQ-016 Load (flush=0, stall=0): on each rising edge, every `_out` SHALL take its `_in` value and valid_out SHALL go to 1; latency is exactly 1 cycle.
REQ-017 Flush=1: on the next edge, every control `_out` (REQ-006..REQ-008) SHALL be 0 and every datapath/specifier `_out` (REQ-009..REQ-011) SHALL be 0.
REQ-018 Flush=1: on the next edge, valid_out SHALL be 0, regardless of stall.
REQ-019 Stall=1 with flush=0: every `_out` and valid_out SHALL keep its value; the `_in` values are discarded.
REQ-020 Flush and stall both 1: the flush behaviour SHALL apply, so a bubble is inserted.
REQ-021 bubble_count SHALL increment by 1 on every edge where flush=1.
REQ-022 bubble_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 bubble_count SHALL be unaffected by stall and by load.
REQ-024 The block SHALL contain no combinational path from any input to any output.
REQ-025 Control bits SHALL pass through unmodified; the block does not interpret opcode semantics.

Reset
REQ-026 While reset=1, all outputs SHALL be 0 immediately (asynchronous, without waiting for a clock edge).
REQ-027 While reset=1, valid_out=0 and bubble_count=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL discard any pending update.
REQ-029 On the first rising edge after reset deasserts, the block SHALL perform a normal load if flush=0 and stall=0.
REQ-030 After reset, outputs SHALL equal a NOP until the first load.

Verification
REQ-031 Load: drive RegWrite_in=1, ALUOp_in=2'b10, RegDst_in=1, rs_in=5'd3, rt_in=5'd4, rd_in=5'd5, funct_in=6'h20, read_data1_in=32'h0000_0010, then one edge -> identical `_out` values and valid_out=1 after exactly one edge.
REQ-032 Stall: load MemRead_in=1, trunk_mode_in=3 (LBU), then assert stall for 3 edges while changing all `_in` -> `_out` stays at the LBU values and valid_out stays 1 for all 3 cycles.
REQ-033 Flush over stall: with a JAL loaded (Jump_out=1, Jdes_sel_out=2'b01), assert flush=1 and stall=1 for one edge -> all `_out`=0, valid_out=0, bubble_count incremented by 1.
REQ-034 Saturation with CNT_W=4: hold flush=1 for 20 edges -> bubble_count reaches 15 and stays at 15.
REQ-035 Asynchronous reset: with MemWrite_out=1, pulse reset between clock edges -> all outputs 0 before the next edge; the first edge after release loads `_in`.
REQ-036 Back-to-back: alternate load / flush / load over 3 edges -> valid_out sequence 1, 0, 1 and bubble_count +1.
